// File: rtl/time_clock_controller.sv
// Run/stop/lap/set-time sequencer for the time-of-day counter, with a CLK_HZ/TICK_HZ tick divider.
// Optional feature macro: LAP_EN (lap-hold display freeze while running).
module time_clock_controller #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_run,
  input  logic       i_btn_mode,
  input  logic       i_btn_lap,
  input  logic       i_btn_up,
  input  logic [5:0] i_hour,
  input  logic [5:0] i_min,
  output logic       o_cnt_en,
  output logic       o_cnt_clr,
  output logic       o_load,
  output logic [5:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic       o_lap_hold,
  output logic [1:0] o_field
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  localparam logic [2:0] ST_STOP     = 3'b000;
  localparam logic [2:0] ST_RUN      = 3'b001;
  localparam logic [2:0] ST_SET_HOUR = 3'b010;
  localparam logic [2:0] ST_SET_MIN  = 3'b100;

  localparam logic [2:0] BTN_NONE = 3'd0;
  localparam logic [2:0] BTN_RUN  = 3'd1;
  localparam logic [2:0] BTN_MODE = 3'd2;
  localparam logic [2:0] BTN_LAP  = 3'd3;
  localparam logic [2:0] BTN_UP   = 3'd4;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  // Saturating-range increment: anything at or above top wraps to zero.
  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] top);
    if (val >= top) begin
      return 6'd0;
    end else begin
      return val + 6'd1;
    end
  endfunction

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic             lap_hold_q, lap_hold_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic             load_q, load_d;
  logic [1:0]       field_q, field_d;
  logic [2:0]       btn_sel_s;

  // Priority-select a single button: run > mode > lap > up.
  always_comb begin
    if (i_btn_run) begin
      btn_sel_s = BTN_RUN;
    end else if (i_btn_mode) begin
      btn_sel_s = BTN_MODE;
    end else if (i_btn_lap) begin
      btn_sel_s = BTN_LAP;
    end else if (i_btn_up) begin
      btn_sel_s = BTN_UP;
    end else begin
      btn_sel_s = BTN_NONE;
    end
  end

  // Next-state, divider and edit-register logic.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    hour_d     = hour_q;
    min_d      = min_q;
    lap_hold_d = lap_hold_q;
    cnt_en_d   = 1'b0;
    cnt_clr_d  = 1'b0;
    load_d     = 1'b0;
    case (state_q)
      ST_STOP: begin
        case (btn_sel_s)
          BTN_RUN:  state_d = ST_RUN;
          BTN_MODE: begin
            state_d = ST_SET_HOUR;
            hour_d  = i_hour;
            min_d   = i_min;
          end
          BTN_LAP: begin
            cnt_clr_d  = 1'b1;
            div_d      = DIV_ZERO;
            lap_hold_d = 1'b0;
          end
          default: state_d = ST_STOP;
        endcase
      end
      ST_RUN: begin
        if (btn_sel_s == BTN_RUN) begin
          // Divider holds so a resume continues the partial tick period.
          state_d = ST_STOP;
        end else begin
          if (div_q == DIV_LAST) begin
            div_d    = DIV_ZERO;
            cnt_en_d = 1'b1;
          end else begin
            div_d = div_q + DIV_ONE;
          end
`ifdef LAP_EN
          if (btn_sel_s == BTN_LAP) begin
            lap_hold_d = ~lap_hold_q;
          end else begin
            lap_hold_d = lap_hold_q;
          end
`endif
        end
      end
      ST_SET_HOUR: begin
        case (btn_sel_s)
          BTN_RUN:  state_d = ST_STOP;
          BTN_MODE: state_d = ST_SET_MIN;
          BTN_UP:   hour_d  = wrap_inc(hour_q, 6'd23);
          default:  state_d = ST_SET_HOUR;
        endcase
      end
      ST_SET_MIN: begin
        case (btn_sel_s)
          BTN_RUN: state_d = ST_STOP;
          BTN_MODE: begin
            state_d = ST_STOP;
            load_d  = 1'b1;
            div_d   = DIV_ZERO;
          end
          BTN_UP:  min_d   = wrap_inc(min_q, 6'd59);
          default: state_d = ST_SET_MIN;
        endcase
      end
      default: state_d = ST_STOP;
    endcase
`ifndef LAP_EN
    lap_hold_d = 1'b0;
`endif
  end

  // Blink-field decode registered alongside the state it describes.
  always_comb begin
    case (state_d)
      ST_SET_HOUR: field_d = FIELD_HOUR;
      ST_SET_MIN:  field_d = FIELD_MIN;
      default:     field_d = FIELD_NONE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_STOP;
      div_q      <= DIV_ZERO;
      hour_q     <= 6'd0;
      min_q      <= 6'd0;
      lap_hold_q <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      load_q     <= 1'b0;
      field_q    <= FIELD_NONE;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      lap_hold_q <= lap_hold_d;
      cnt_en_q   <= cnt_en_d;
      cnt_clr_q  <= cnt_clr_d;
      load_q     <= load_d;
      field_q    <= field_d;
    end
  end

  assign o_cnt_en   = cnt_en_q;
  assign o_cnt_clr  = cnt_clr_q;
  assign o_load     = load_q;
  assign o_set_hour = hour_q;
  assign o_set_min  = min_q;
  assign o_lap_hold = lap_hold_q;
  assign o_field    = field_q;

endmodule

// File: tb/tb_time_clock_controller.sv
// Scoreboard bench for time_clock_controller with DIV=10 (CLK_HZ=10, TICK_HZ=1).
module tb_time_clock_controller;

  localparam int DIV = 10;
`ifdef LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_run, btn_mode, btn_lap, btn_up;
  logic [5:0] hour_in, min_in;
  logic       cnt_en, cnt_clr, load, lap_hold;
  logic [5:0] set_hour, set_min;
  logic [1:0] field;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  // Reference model state: 0 stop, 1 run, 2 set hour, 3 set minute
  int         m_st, m_div;
  logic       m_en, m_clr, m_load, m_hold;
  logic [5:0] m_h, m_m;

  always #5 clk = ~clk;

  time_clock_controller #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_btn_run(btn_run), .i_btn_mode(btn_mode), .i_btn_lap(btn_lap), .i_btn_up(btn_up),
    .i_hour(hour_in), .i_min(min_in),
    .o_cnt_en(cnt_en), .o_cnt_clr(cnt_clr), .o_load(load),
    .o_set_hour(set_hour), .o_set_min(set_min),
    .o_lap_hold(lap_hold), .o_field(field)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] dut_outs();
    return {cnt_en, cnt_clr, load, lap_hold, field, set_hour, set_min};
  endfunction

  function automatic logic [17:0] model_outs();
    logic [1:0] f;
    f = (m_st == 2) ? 2'b01 : (m_st == 3) ? 2'b10 : 2'b00;
    return {m_en, m_clr, m_load, m_hold, f, m_h, m_m};
  endfunction

  task automatic model_reset();
    m_st = 0; m_div = 0; m_en = 1'b0; m_clr = 1'b0; m_load = 1'b0; m_hold = 1'b0;
    m_h = 6'd0; m_m = 6'd0;
  endtask

  task automatic model_step(input bit r, input bit mo, input bit la, input bit u);
    m_en = 1'b0; m_clr = 1'b0; m_load = 1'b0;
    case (m_st)
      0: begin
        if (r) m_st = 1;
        else if (mo) begin m_st = 2; m_h = hour_in; m_m = min_in; end
        else if (la) begin m_clr = 1'b1; m_div = 0; m_hold = 1'b0; end
      end
      1: begin
        if (r) m_st = 0;
        else begin
          if (m_div == DIV - 1) begin m_div = 0; m_en = 1'b1; end
          else m_div = m_div + 1;
          if (!mo && la && LAP) m_hold = ~m_hold;
        end
      end
      2: begin
        if (r) m_st = 0;
        else if (mo) m_st = 3;
        else if (!la && u) m_h = (m_h == 6'd23) ? 6'd0 : m_h + 6'd1;
      end
      default: begin
        if (r) m_st = 0;
        else if (mo) begin m_st = 0; m_load = 1'b1; m_div = 0; end
        else if (!la && u) m_m = (m_m == 6'd59) ? 6'd0 : m_m + 6'd1;
      end
    endcase
  endtask

  // One clock: drive pulses at negedge, push model expectation, compare after the edge.
  task automatic cycle(input bit r, input bit mo, input bit la, input bit u);
    logic [17:0] e;
    @(negedge clk);
    btn_run = r; btn_mode = mo; btn_lap = la; btn_up = u;
    model_step(r, mo, la, u);
    exp_q.push_back(model_outs());
    @(posedge clk);
    #1;
    btn_run = 1'b0; btn_mode = 1'b0; btn_lap = 1'b0; btn_up = 1'b0;
    e = exp_q.pop_front();
    check_eq("sb_outs", 32'(dut_outs()), 32'(e));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Idle until a tick is seen or the budget runs out; k = cycles taken, -1 on timeout.
  task automatic wait_tick(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (cnt_en === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k, n;
    rst_n = 1'b0;
    btn_run = 1'b0; btn_mode = 1'b0; btn_lap = 1'b0; btn_up = 1'b0;
    hour_in = 6'd0; min_in = 6'd0;
    model_reset();
    #12;
    check_eq("reset_outs", 32'(dut_outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Run: ticks at 10, 20, 30 cycles after entry
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (cnt_en === 1'b1) begin
        check_eq("tick_pos", 32'(i), 32'(10 * (n + 1)));
        n++;
      end
    end
    check_eq("tick_count", 32'(n), 32'd3);

    // Stop at div=4, idle, resume: next tick 6 cycles in
    idle(4);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (cnt_en === 1'b1) n++;
    end
    check_eq("stopped_ticks", 32'(n), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    wait_tick(15, k);
    check_eq("resume_tick", 32'(k), 32'd6);

    // Clear in STOP, then run+lap together starts RUN without a clear
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("clr_pulse", 32'(cnt_clr), 32'd1);
    idle(1);
    check_eq("clr_one_cycle", 32'(cnt_clr), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("runlap_no_clr", 32'(cnt_clr), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("lap_hold_on", 32'(lap_hold), 32'(LAP));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("lap_hold_off", 32'(lap_hold), 32'd0);
    wait_tick(15, k);
    check_eq("tick_after_clr", 32'(k), 32'd8);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Set time from 23:59: hour wraps to 0, minute 59 -> 0 -> 1, then commit
    hour_in = 6'd23; min_in = 6'd59;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("field_hour", 32'(field), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("hour_wrap", 32'(set_hour), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("field_min", 32'(field), 32'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("min_wrap", 32'(set_min), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("load_pulse", 32'({load, cnt_clr, set_hour, set_min, field}), 32'({1'b1, 1'b0, 6'd0, 6'd1, 2'b00}));
    idle(1);
    check_eq("load_one_cycle", 32'(load), 32'd0);

    // Cancel from SET_MIN: no load
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("cancel_no_load", 32'({load, field}), 32'd0);

    // Priority in STOP: mode beats lap and up
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("prio_mode", 32'({cnt_clr, field}), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrun_reset", 32'(dut_outs()), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
